seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised time-multiplexed 7-segment display controller for board-level debug output. Drives NUM_DIGITS common-select digits from a packed hex word. Adds per-digit decimal point and blanking, leading-zero suppression, and PWM brightness. A shadow/active register pair, loaded by strobe, prevents tearing mid-frame.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16)
DIV_W, 15, prescaler width; each digit slot lasts 2^DIV_W clk cycles
PWM_W, 4, brightness resolution in bits; PWM_W <= DIV_W required
ACTIVE_LOW, 1, 1: o_seg and o_sel lit/enabled when 0; 0: lit/enabled when 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
i_data  in  4*NUM_DIGITS  hex nibbles; nibble k ([4k+3:4k]) drives digit k; digit 0 is least significant
i_dp  in  NUM_DIGITS  decimal point enable per digit
i_blank  in  NUM_DIGITS  force digit k fully dark: segments, dp and select
i_lz_sup  in  1  leading-zero suppression enable
i_load  in  1  one-cycle strobe; captures i_data/i_dp/i_blank/i_lz_sup into shadow
i_brightness  in  PWM_W  duty level; 0 is dimmest, all-ones is full on
o_seg  out  8  segment bus {dp,g,f,e,d,c,b,a}
o_sel  out  NUM_DIGITS  one-hot digit select
o_frame  out  1  one-cycle pulse when scan wraps to digit 0

Behaviour:
- Reset (reset=0, async): prescaler=0, digit index=0, shadow=0, active=0, pending=0; o_seg=all off (8'hFF if ACTIVE_LOW, else 8'h00); o_sel=all off; o_frame=0.
- Prescaler: DIV_W-bit counter, +1 every clk, wraps naturally.
- Digit index: advances when prescaler == all-ones; wraps NUM_DIGITS-1 -> 0. Non-power-of-2 NUM_DIGITS wraps explicitly.
- i_load: shadow <= inputs; pending <= 1. Back-to-back loads overwrite shadow (last load wins).
- Commit: on the edge where index wraps to 0, if pending, active <= shadow and pending <= 0.
- i_load on the commit edge: the i_load values bypass directly into active; pending ends 0.
- Leading-zero suppression, computed from active: digits from NUM_DIGITS-1 downward with nibble 0 have segments a-g dark, until the first nonzero nibble. Digit 0 is never suppressed. The dp of a suppressed digit still follows i_dp; its select stays on.
- Blank: active blank bit k forces o_seg all-off and o_sel bit k off while digit k is scanned.
- PWM: phase = prescaler[DIV_W-1 -: PWM_W]. The select is enabled only when phase <= i_brightness, so duty = (brightness+1)/2^PWM_W. When the select is disabled, o_seg is also all-off.
- Encoding, active-high internal values {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. dp is bit 7. ACTIVE_LOW inverts all 8 bits, e.g. '0' without dp = 8'hC0.
- Latency: o_seg/o_sel are registered, 1 clk after index/prescaler. Both update on the same edge; no select/segment skew.
- o_frame: registered, high the cycle o_sel first shows digit 0 of a new frame.
- Reset mid-frame: all state clears immediately; scan restarts at digit 0; the pending load is lost.

Test Plan:
1. DIV_W=4, PWM_W=2, ACTIVE_LOW=1, brightness=3. Release reset, load i_data=32'h0123_4567 -> after the first frame wrap, digit 0 slot shows o_sel=8'hFE, o_seg=8'hF8. Digit 7 shows o_seg=8'hC0. Each slot lasts 16 clk. o_frame pulses every 128 clk.
2. Load 32'h0000_00A0 with i_lz_sup=1 -> digits 7..2 have o_seg=8'hFF with select still active; digit 1 shows 8'h88; digit 0 shows 8'hC0. Set i_dp[3]=1 and reload -> digit 3 shows 8'h7F.
3. i_blank=8'h80 -> o_sel[7] never asserts; o_seg=8'hFF during slot 7.
4. brightness=0 -> within each 16-clk slot, select is active for only 4 clk and o_seg is 8'hFF otherwise. brightness=1 -> 8 clk active.
5. i_load 32'h1111_1111 at mid-frame (slot 3) -> remaining slots of that frame keep old data; new data appears from next digit 0. A second load in the same frame -> only the later value is displayed.
6. i_load on the exact commit edge -> those values display in the frame just starting. Assert reset mid-slot -> o_seg=8'hFF and o_sel=8'hFF immediately; after release, scan restarts at digit 0 showing 0 data.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with shadow/active content registers,
// leading-zero suppression, per-digit blanking and PWM brightness.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_W      = 15,
    parameter int PWM_W      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic                    i_lz_sup,
    input  logic                    i_load,
    input  logic [PWM_W-1:0]        i_brightness,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_sel,
    output logic                    o_frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]        r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_data,  r_act_data;
    logic [NUM_DIGITS-1:0]   r_sh_dp,    r_act_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank, r_act_blank;
    logic                    r_sh_lz,    r_act_lz;
    logic                    r_pending;
    logic                    r_wrapped;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic                    r_frame;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [3:0]              w_nib;
    logic                    w_still_zero;
    logic [NUM_DIGITS-1:0]   w_sup;
    logic [PWM_W-1:0]        w_phase;
    logic                    w_lit;
    logic [7:0]              w_pattern;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;

    function automatic logic [6:0] f_hex(input logic [3:0] nib);
        case (nib)
            4'h0: f_hex = 7'h3F;
            4'h1: f_hex = 7'h06;
            4'h2: f_hex = 7'h5B;
            4'h3: f_hex = 7'h4F;
            4'h4: f_hex = 7'h66;
            4'h5: f_hex = 7'h6D;
            4'h6: f_hex = 7'h7D;
            4'h7: f_hex = 7'h07;
            4'h8: f_hex = 7'h7F;
            4'h9: f_hex = 7'h6F;
            4'hA: f_hex = 7'h77;
            4'hB: f_hex = 7'h7C;
            4'hC: f_hex = 7'h39;
            4'hD: f_hex = 7'h5E;
            4'hE: f_hex = 7'h79;
            default: f_hex = 7'h71;
        endcase
    endfunction

    assign w_slot_end = &r_presc;
    assign w_wrap     = w_slot_end && (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_slot_end)
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // A load landing on the wrap edge bypasses the shadow so it shows in the new frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh_data   <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_sh_lz     <= 1'b0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_act_lz    <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            if (i_load) begin
                r_sh_data  <= i_data;
                r_sh_dp    <= i_dp;
                r_sh_blank <= i_blank;
                r_sh_lz    <= i_lz_sup;
            end
            if (w_wrap) begin
                r_pending <= 1'b0;
                if (i_load) begin
                    r_act_data  <= i_data;
                    r_act_dp    <= i_dp;
                    r_act_blank <= i_blank;
                    r_act_lz    <= i_lz_sup;
                end else if (r_pending) begin
                    r_act_data  <= r_sh_data;
                    r_act_dp    <= r_sh_dp;
                    r_act_blank <= r_sh_blank;
                    r_act_lz    <= r_sh_lz;
                end
            end else if (i_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_still_zero = 1'b1;
        w_sup        = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            w_still_zero = w_still_zero && (r_act_data[4*(NUM_DIGITS-i) +: 4] == 4'h0);
            w_sup[NUM_DIGITS-i] = w_still_zero && r_act_lz;
        end
        w_nib     = r_act_data[{r_idx, 2'b00} +: 4];
        w_pattern = {r_act_dp[r_idx], w_sup[r_idx] ? 7'h00 : f_hex(w_nib)};
        w_phase   = r_presc[DIV_W-1 -: PWM_W];
        w_lit     = !r_act_blank[r_idx] && (w_phase <= i_brightness);
        w_seg_nxt = w_lit ? w_pattern : 8'h00;
        w_sel_nxt = w_lit ? (NUM_DIGITS'(1) << r_idx) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg     <= SEG_OFF;
            r_sel     <= SEL_OFF;
            r_wrapped <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_seg     <= (ACTIVE_LOW != 0) ? ~w_seg_nxt : w_seg_nxt;
            r_sel     <= (ACTIVE_LOW != 0) ? ~w_sel_nxt : w_sel_nxt;
            r_wrapped <= w_wrap;
            r_frame   <= r_wrapped;
        end
    end

    assign o_seg   = r_seg;
    assign o_sel   = r_sel;
    assign o_frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: constant vector table, hand-written timing sequences,
// and a per-cycle monitor comparing against a frame-level reference model.
module tb_seg7_scan_ctrl;

    localparam int N  = 8;
    localparam int DW = 4;
    localparam int PW = 2;
    localparam int unsigned SLOT  = 16;
    localparam int unsigned FRAME = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   i_data;
    logic [7:0]    i_dp, i_blank;
    logic          i_lz_sup, i_load;
    logic [PW-1:0] i_brightness;
    logic [7:0]    o_seg;
    logic [N-1:0]  o_sel;
    logic          o_frame;

    seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV_W(DW), .PWM_W(PW), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .i_data(i_data), .i_dp(i_dp), .i_blank(i_blank),
        .i_lz_sup(i_lz_sup), .i_load(i_load), .i_brightness(i_brightness),
        .o_seg(o_seg), .o_sel(o_sel), .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int unsigned at;
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        lz;
    } load_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        lz;
        logic [1:0]  br;
        int unsigned digit;
        int unsigned off;
        logic [7:0]  seg;
        logic [7:0]  sel;
    } vec_t;

    load_t       loads[$];
    int unsigned n_edge = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Content shown at edge n is the last load made in any earlier frame.
    function automatic void model(input int unsigned n, input logic [1:0] br,
                                  output logic [7:0] seg, output logic [7:0] sel,
                                  output logic frm);
        load_t       act;
        int unsigned d, ph;
        logic [7:0]  pat;
        logic        sup, lit;
        act = '{at: 0, data: 32'h0, dp: 8'h0, blank: 8'h0, lz: 1'b0};
        foreach (loads[i])
            if (loads[i].at / FRAME < n / FRAME) act = loads[i];
        d   = (n / SLOT) % N;
        ph  = (n % SLOT) / 4;
        sup = act.lz && (d != 0) && ((act.data >> (4 * d)) == 32'h0);
        pat = {act.dp[d], sup ? 7'h00 : HEX[act.data[4*d +: 4]]};
        lit = !act.blank[d] && (ph <= int'(br));
        seg = lit ? ~pat : 8'hFF;
        sel = lit ? ~(8'h01 << d) : 8'hFF;
        frm = (n != 0) && (n % FRAME == 0);
    endfunction

    logic       m_ld, m_lz, m_frm;
    logic [1:0] m_br;
    logic [31:0] m_data;
    logic [7:0] m_dp, m_bl, m_seg, m_sel;

    always begin
        @(posedge clk);
        if (!reset) begin
            n_edge = 0;
            loads.delete();
            #1;
            chk("rst_seg", o_seg, 8'hFF);
            chk("rst_sel", o_sel, 8'hFF);
            chk("rst_frame", o_frame, 1'b0);
        end else begin
            m_ld = i_load; m_data = i_data; m_dp = i_dp; m_bl = i_blank;
            m_lz = i_lz_sup; m_br = i_brightness;
            #1;
            model(n_edge, m_br, m_seg, m_sel, m_frm);
            chk("mon_seg", o_seg, m_seg);
            chk("mon_sel", o_sel, m_sel);
            chk("mon_frame", o_frame, m_frm);
            if (m_ld)
                loads.push_back('{at: n_edge, data: m_data, dp: m_dp, blank: m_bl, lz: m_lz});
            n_edge++;
        end
    end

    task automatic wait_edge(input int unsigned target);
        int guard = 0;
        while (n_edge != target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (n_edge != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_edge: reached edge %0d required %0d", n_edge, target);
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                           input logic lz);
        i_load = 1'b1; i_data = d; i_dp = dp; i_blank = bl; i_lz_sup = lz;
        @(negedge clk);
        i_load = 1'b0;
    endtask

    task automatic measure_frame(input logic [1:0] br, input int exp_on);
        int guard = 0;
        int per = 0;
        int on = 0;
        i_brightness = br;
        do begin @(posedge clk); #1; guard++; end while (!o_frame && guard < 400);
        chk("frame_seen", o_frame, 1'b1);
        on = int'(o_sel == 8'hFE);
        do begin
            @(posedge clk); #1;
            per++;
            if (!o_frame) on += int'(o_sel == 8'hFE);
        end while (!o_frame && per < 400);
        chk("frame_period", per, FRAME);
        chk("slot_on_cycles", on, exp_on);
        @(negedge clk);
    endtask

    vec_t        tbl[20];
    int unsigned cur, fs;

    initial begin
        tbl[0]  = '{32'h0123_4567, 8'h00, 8'h00, 1'b0, 2'd3, 0, 0, 8'hF8, 8'hFE};
        tbl[1]  = '{32'h0123_4567, 8'h00, 8'h00, 1'b0, 2'd3, 7, 5, 8'hC0, 8'h7F};
        tbl[2]  = '{32'h0000_00A0, 8'h00, 8'h00, 1'b1, 2'd3, 7, 0, 8'hFF, 8'h7F};
        tbl[3]  = '{32'h0000_00A0, 8'h00, 8'h00, 1'b1, 2'd3, 2, 0, 8'hFF, 8'hFB};
        tbl[4]  = '{32'h0000_00A0, 8'h00, 8'h00, 1'b1, 2'd3, 1, 0, 8'h88, 8'hFD};
        tbl[5]  = '{32'h0000_00A0, 8'h00, 8'h00, 1'b1, 2'd3, 0, 0, 8'hC0, 8'hFE};
        tbl[6]  = '{32'h0000_00A0, 8'h08, 8'h00, 1'b1, 2'd3, 3, 0, 8'h7F, 8'hF7};
        tbl[7]  = '{32'h0123_4567, 8'h00, 8'h80, 1'b0, 2'd3, 7, 0, 8'hFF, 8'hFF};
        tbl[8]  = '{32'h0123_4567, 8'h00, 8'h80, 1'b0, 2'd3, 6, 0, 8'hF9, 8'hBF};
        tbl[9]  = '{32'hFFFF_FFFF, 8'h00, 8'h00, 1'b0, 2'd3, 4, 0, 8'h8E, 8'hEF};
        tbl[10] = '{32'h8000_0000, 8'h00, 8'h00, 1'b1, 2'd3, 7, 0, 8'h80, 8'h7F};
        tbl[11] = '{32'h8000_0000, 8'h00, 8'h00, 1'b1, 2'd3, 6, 0, 8'hC0, 8'hBF};
        tbl[12] = '{32'h0000_0000, 8'h00, 8'h00, 1'b1, 2'd3, 0, 0, 8'hC0, 8'hFE};
        tbl[13] = '{32'h0123_4567, 8'h00, 8'h00, 1'b0, 2'd0, 2, 3, 8'h92, 8'hFB};
        tbl[14] = '{32'h0123_4567, 8'h00, 8'h00, 1'b0, 2'd0, 2, 4, 8'hFF, 8'hFF};
        tbl[15] = '{32'h0123_4567, 8'h00, 8'h00, 1'b0, 2'd1, 2, 7, 8'h92, 8'hFB};
        tbl[16] = '{32'h0123_4567, 8'h00, 8'h00, 1'b0, 2'd1, 2, 8, 8'hFF, 8'hFF};
        tbl[17] = '{32'h0123_4567, 8'h00, 8'h00, 1'b0, 2'd2, 2, 12, 8'hFF, 8'hFF};
        tbl[18] = '{32'hDEAD_BEEF, 8'hFF, 8'h00, 1'b0, 2'd3, 5, 0, 8'h08, 8'hDF};
        tbl[19] = '{32'hDEAD_BEEF, 8'hFF, 8'h00, 1'b0, 2'd3, 7, 0, 8'h21, 8'h7F};

        i_load = 1'b0; i_data = '0; i_dp = '0; i_blank = '0; i_lz_sup = 1'b0;
        i_brightness = 2'd3;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            cur = n_edge;
            i_brightness = tbl[i].br;
            do_load(tbl[i].data, tbl[i].dp, tbl[i].blank, tbl[i].lz);
            wait_edge((cur / FRAME + 1) * FRAME + tbl[i].digit * SLOT + tbl[i].off);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_seg", i), o_seg, tbl[i].seg);
            chk($sformatf("vec%0d_sel", i), o_sel, tbl[i].sel);
            @(negedge clk);
        end

        // Mid-frame load and double load within one frame
        i_brightness = 2'd3;
        fs = (n_edge / FRAME + 1) * FRAME;
        wait_edge(fs + 10);
        do_load(32'h7654_3210, 8'h00, 8'h00, 1'b0);
        fs = fs + FRAME;
        wait_edge(fs + 3 * SLOT + 5);
        do_load(32'h1111_1111, 8'h00, 8'h00, 1'b0);
        wait_edge(fs + 5 * SLOT + 2);
        @(posedge clk); #1;
        chk("midload_old", o_seg, 8'h92);
        @(negedge clk);
        wait_edge(fs + FRAME);
        @(posedge clk); #1;
        chk("midload_new_seg", o_seg, 8'hF9);
        chk("midload_new_sel", o_sel, 8'hFE);
        @(negedge clk);
        wait_edge(fs + FRAME + 2 * SLOT);
        do_load(32'h2222_2222, 8'h00, 8'h00, 1'b0);
        wait_edge(fs + FRAME + 5 * SLOT);
        do_load(32'h3333_3333, 8'h00, 8'h00, 1'b0);
        wait_edge(fs + FRAME + 6 * SLOT + 1);
        @(posedge clk); #1;
        chk("dblload_old", o_seg, 8'hF9);
        @(negedge clk);
        wait_edge(fs + 2 * FRAME);
        @(posedge clk); #1;
        chk("dblload_last", o_seg, 8'hB0);
        @(negedge clk);

        // Load exactly on the commit edge
        fs = (n_edge / FRAME + 1) * FRAME;
        wait_edge(fs + FRAME - 1);
        do_load(32'h5555_5555, 8'h00, 8'h00, 1'b0);
        wait_edge(fs + FRAME);
        @(posedge clk); #1;
        chk("commit_edge_seg", o_seg, 8'h92);
        chk("commit_edge_frame", o_frame, 1'b1);
        @(negedge clk);

        measure_frame(2'd3, 16);
        measure_frame(2'd0, 4);
        measure_frame(2'd1, 8);
        i_brightness = 2'd3;

        // Reset mid-slot with a load still pending
        fs = (n_edge / FRAME + 1) * FRAME;
        wait_edge(fs + 3 * SLOT + 7);
        do_load(32'h9999_9999, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_rst_seg", o_seg, 8'hFF);
        chk("async_rst_sel", o_sel, 8'hFF);
        chk("async_rst_frame", o_frame, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_sel", o_sel, 8'hFE);
        chk("post_rst_seg", o_seg, 8'hC0);
        @(negedge clk);
        wait_edge(FRAME);
        @(posedge clk); #1;
        chk("pending_lost", o_seg, 8'hC0);
        @(negedge clk);

        // Random loads and brightness changes, checked by the monitor
        for (int c = 0; c < 1200; c++) begin
            if (c % 50 == 0) i_brightness = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0)
                do_load($urandom >> (4 * $urandom_range(0, 8)), 8'($urandom),
                        8'($urandom & $urandom & $urandom), 1'($urandom));
            else
                @(negedge clk);
        end
        repeat (2 * FRAME) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
